word_serializer: RTL and testbench

- Parallel-to-serial transmitter: accepts a WIDTH-bit word on a valid/ready handshake and emits it on a single wire as a framed bit stream.
- Frame: start bit, data bits LSB first, optional even-parity bit, stop bit.
- It is the transmit end paired with the existing 5-bit bus receivers in the netlist benchmark set.
- One-entry holding buffer lets the next word be accepted while a frame is in flight, giving gap-free back-to-back frames.

---
 rtl/word_serializer_pkg.sv | 17 +
 rtl/word_serializer_bit_timer.sv | 37 +++
 rtl/word_serializer.sv | 160 ++++++++++++++++
 tb/tb_word_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the framed parallel-to-serial transmitter.
package word_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Serial bit periods in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned width, input bit parity_en);
    return width + 32'd2 + (parity_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/word_serializer_bit_timer.sv
// Bit-period timer: tick marks the last clock of each DIV-cycle serial bit.
module bit_timer
  import word_serializer_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign tick = run && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Framed serial transmitter with a one-word holding buffer for gap-free
// back-to-back frames: start(0), data LSB first, optional even parity, stop(1).
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned DIV       = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_o,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [WIDTH-1:0] shifted;
  logic [IW-1:0]    idx_q, idx_d;
  logic             par_q, par_d;
  logic             hold_full_q, hold_full_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             load;
  logic             tick;

  bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_q != IDLE),
    .tick (tick)
  );

  assign shifted = shift_q >> 1;

  // Next-state: frame sequencing, hold-buffer refill and accept.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    par_d       = par_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    ser_d       = ser_q;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          ser_d   = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_BIT) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              ser_d   = par_q;
            end else begin
              state_d = STOP;
              ser_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IW'(1);
            shift_d = shifted;
            ser_d   = shifted[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          ser_d   = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            ser_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = 1'b1;
      end
    endcase

    // Parity is latched from the word as loaded, not the shifting copy.
    if (load) begin
      state_d     = START;
      shift_d     = hold_data_q;
      par_d       = ^hold_data_q;
      idx_d       = '0;
      hold_full_d = 1'b0;
      ser_d       = 1'b0;
    end

    if (in_valid && ready_q) begin
      hold_full_d = 1'b1;
      hold_data_d = in_data;
    end
  end

  assign busy_d  = (state_d != IDLE);
  assign ready_d = !hold_full_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      par_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      ser_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      ser_q       <= ser_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign in_ready   = ready_q;
  assign ser_o      = ser_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench: DUT A (DIV=1, parity) and DUT B (DIV=4, no parity).
module tb_word_serializer;
  import word_serializer_pkg::*;

  localparam int unsigned B_LEN = frame_bits(5, 1'b0) * 4;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_ready, a_ser, a_busy, a_done;
  logic [4:0] a_data;
  logic       b_valid, b_ready, b_ser, b_busy, b_done;
  logic [4:0] b_data;

  int chk_cnt;
  int pass_cnt;

  word_serializer #(.WIDTH(5), .DIV(1), .PARITY_EN(1'b1)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_valid),
    .in_data   (a_data),
    .in_ready  (a_ready),
    .ser_o     (a_ser),
    .busy      (a_busy),
    .frame_done(a_done)
  );

  word_serializer #(.WIDTH(5), .DIV(4), .PARITY_EN(1'b0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_valid),
    .in_data   (b_data),
    .in_ready  (b_ready),
    .ser_o     (b_ser),
    .busy      (b_busy),
    .frame_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected parity frame, bit 0 on the wire first.
  function automatic logic [7:0] frame_of(input logic [4:0] w);
    return {1'b1, ^w, w, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({a_ser, a_ready, a_busy, a_done} !== 4'b1100)
      $display("FAIL reset_held_a: got %b expected 1100", {a_ser, a_ready, a_busy, a_done});
    else pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({a_ser, a_ready, a_busy, a_done} !== 4'b1100)
        $display("FAIL reset_idle_a[%0d]: got %b expected 1100", i, {a_ser, a_ready, a_busy, a_done});
      else pass_cnt++;
      chk_cnt++;
      if ({b_ser, b_ready, b_busy, b_done} !== 4'b1100)
        $display("FAIL reset_idle_b[%0d]: got %b expected 1100", i, {b_ser, b_ready, b_busy, b_done});
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_bits;
    exp_bits = 8'b1111_0100;  // 0,0,1,0,1,1,1,1 for 5'h1A
    @(negedge clk);
    a_valid = 1'b1; a_data = 5'h1A;
    @(negedge clk);
    a_valid = 1'b0;
    chk_cnt++;
    if ({a_ready, a_ser} !== 2'b01)
      $display("FAIL single_accept: got ready/ser %b expected 01", {a_ready, a_ser});
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({a_ser, a_busy, a_done} !== {exp_bits[i], 2'b10})
        $display("FAIL single_bit[%0d]: got ser/busy/done %b expected %b", i,
                 {a_ser, a_busy, a_done}, {exp_bits[i], 2'b10});
      else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++;
    if ({a_ser, a_busy, a_done} !== 3'b101)
      $display("FAIL single_done: got ser/busy/done %b expected 101", {a_ser, a_busy, a_done});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (a_done !== 1'b0)
      $display("FAIL single_done_width: got %b expected 0", a_done);
    else pass_cnt++;
  endtask

  task automatic test_timing();
    logic [6:0] exp_bits;
    exp_bits = 7'b1_00001_0;  // start, data 1,0,0,0,0, stop
    @(negedge clk);
    b_valid = 1'b1; b_data = 5'h01;
    @(negedge clk);
    b_valid = 1'b0;
    chk_cnt++;
    if ({b_ready, b_ser} !== 2'b01)
      $display("FAIL timing_accept: got ready/ser %b expected 01", {b_ready, b_ser});
    else pass_cnt++;
    for (int c = 0; c < int'(B_LEN); c++) begin
      @(negedge clk);
      chk_cnt++;
      if ({b_ser, b_busy, b_done} !== {exp_bits[c/4], 2'b10})
        $display("FAIL timing_cycle[%0d]: got ser/busy/done %b expected %b", c,
                 {b_ser, b_busy, b_done}, {exp_bits[c/4], 2'b10});
      else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++;
    if ({b_ser, b_busy, b_done} !== 3'b101)
      $display("FAIL timing_done: got ser/busy/done %b expected 101", {b_ser, b_busy, b_done});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits;
    logic        exp_ready;
    exp_bits = 16'b1000_0000_1111_1110;  // 0,1,1,1,1,1,1,1 then 0,0,0,0,0,0,0,1
    @(negedge clk);
    a_valid = 1'b1; a_data = 5'h1F;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_ready = !((i >= 3) && (i <= 7));
      chk_cnt++;
      if ({a_ser, a_busy, a_done, a_ready} !== {exp_bits[i], 1'b1, (i == 8), exp_ready})
        $display("FAIL b2b_cycle[%0d]: got ser/busy/done/ready %b expected %b", i,
                 {a_ser, a_busy, a_done, a_ready}, {exp_bits[i], 1'b1, (i == 8), exp_ready});
      else pass_cnt++;
      if (i == 2) begin
        a_valid = 1'b1; a_data = 5'h00;
      end else begin
        a_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk_cnt++;
    if ({a_ser, a_busy, a_done} !== 3'b101)
      $display("FAIL b2b_done: got ser/busy/done %b expected 101", {a_ser, a_busy, a_done});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [25:0] stream;
    logic [4:0]  words [3];
    logic [7:0]  got_f, exp_f;
    // Ready is high at offers 0, 2 and 10; every other offered word is dropped.
    words[0] = 5'(0 * 7 + 3);
    words[1] = 5'(2 * 7 + 3);
    words[2] = 5'(10 * 7 + 3);
    @(negedge clk);
    for (int t = 0; t < 26; t++) begin
      if (t > 0) @(negedge clk);
      stream[t] = a_ser;
      a_valid   = (t < 12);
      a_data    = 5'(t * 7 + 3);
    end
    for (int f = 0; f < 3; f++) begin
      got_f = stream[2 + 8*f +: 8];
      exp_f = frame_of(words[f]);
      chk_cnt++;
      if (got_f !== exp_f)
        $display("FAIL backpressure_frame[%0d]: got %b expected %b", f, got_f, exp_f);
      else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++;
    if ({a_ser, a_busy, a_done, a_ready} !== 4'b1011)
      $display("FAIL backpressure_end: got ser/busy/done/ready %b expected 1011",
               {a_ser, a_busy, a_done, a_ready});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_f;
    @(negedge clk);
    a_valid = 1'b1; a_data = 5'h15;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (4) @(negedge clk);  // now inside data bit 2
    chk_cnt++;
    if ({a_ser, a_busy} !== 2'b11)
      $display("FAIL rstmid_pre: got ser/busy %b expected 11", {a_ser, a_busy});
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({a_ser, a_ready, a_busy, a_done} !== 4'b1100)
      $display("FAIL rstmid_async: got %b expected 1100", {a_ser, a_ready, a_busy, a_done});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({a_ser, a_ready, a_busy} !== 3'b110)
        $display("FAIL rstmid_after[%0d]: got ser/ready/busy %b expected 110", i,
                 {a_ser, a_ready, a_busy});
      else pass_cnt++;
    end
    exp_f = frame_of(5'h0A);
    a_valid = 1'b1; a_data = 5'h0A;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({a_ser, a_busy} !== {exp_f[i], 1'b1})
        $display("FAIL rstmid_frame[%0d]: got ser/busy %b expected %b", i,
                 {a_ser, a_busy}, {exp_f[i], 1'b1});
      else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++;
    if ({a_ser, a_busy, a_done} !== 3'b101)
      $display("FAIL rstmid_done: got ser/busy/done %b expected 101", {a_ser, a_busy, a_done});
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_single();
    test_timing();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
